// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address field helpers for the cache controller.
package cache_pkg;

    localparam int TAG_W      = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 5;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int LINES      = 1 << INDEX_W;
    localparam int ARR_ADDR_W = INDEX_W + OFFSET_W;

    localparam logic [OFFSET_W-1:0] LAST_OFF = {OFFSET_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } cache_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// 256x8 single-port line storage: synchronous write, combinational read at the same address.
module cache_data_array
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [ARR_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_r [0:(1 << ARR_ADDR_W)-1];

    // Byte write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: hit service, dirty write-back and
// line fill over a byte-serial memory handshake.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr_rd,
    input  logic              cpu_cs,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_rd,
    output logic              mem_cs,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              mem_ack
);

    cache_state_t        state_r, state_nxt_s;
    logic [OFFSET_W-1:0] k_r, k_nxt_s, k_inc_s;
    logic [ADDR_W-1:0]   req_addr_r;
    logic                req_wr_r;
    logic [DATA_W-1:0]   req_din_r;
    logic [TAG_W-1:0]    tag_r [LINES];
    logic [LINES-1:0]    valid_r, dirty_r;

    logic                cpu_rdy_r, cpu_rdy_nxt_s;
    logic [DATA_W-1:0]   cpu_dout_r, cpu_dout_nxt_s;
    logic                mem_cs_r, mem_cs_nxt_s;
    logic                mem_wr_rd_r, mem_wr_rd_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0]   mem_dout_r, mem_dout_nxt_s;

    logic [TAG_W-1:0]    req_tag_s;
    logic [INDEX_W-1:0]  req_idx_s;
    logic [OFFSET_W-1:0] req_off_s;
    logic                hit_s;
    logic                accept_s, set_dirty_s, fill_done_s;
    logic                arr_we_s;
    logic [ARR_ADDR_W-1:0] arr_addr_s;
    logic [DATA_W-1:0]   arr_wdata_s, arr_rdata_s;

    assign req_tag_s = addr_tag(req_addr_r);
    assign req_idx_s = addr_idx(req_addr_r);
    assign req_off_s = addr_off(req_addr_r);
    assign hit_s     = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign k_inc_s   = k_r + 5'd1;

    cache_data_array u_data (
        .clk   (clk),
        .we    (arr_we_s & ~rst),
        .addr  (arr_addr_s),
        .wdata (arr_wdata_s),
        .rdata (arr_rdata_s)
    );

    // Next-state, next-output and data-array port control
    always_comb begin
        state_nxt_s     = state_r;
        k_nxt_s         = k_r;
        cpu_rdy_nxt_s   = cpu_rdy_r;
        cpu_dout_nxt_s  = cpu_dout_r;
        mem_cs_nxt_s    = mem_cs_r;
        mem_wr_rd_nxt_s = mem_wr_rd_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_dout_nxt_s  = mem_dout_r;
        accept_s        = 1'b0;
        set_dirty_s     = 1'b0;
        fill_done_s     = 1'b0;
        arr_we_s        = 1'b0;
        arr_addr_s      = {req_idx_s, req_off_s};
        arr_wdata_s     = req_din_r;
        case (state_r)
            IDLE: begin
                if (cpu_cs) begin
                    accept_s      = 1'b1;
                    state_nxt_s   = LOOKUP;
                    cpu_rdy_nxt_s = 1'b0;
                end else begin
                    cpu_rdy_nxt_s = 1'b1;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    state_nxt_s   = IDLE;
                    cpu_rdy_nxt_s = 1'b1;
                    if (req_wr_r) begin
                        arr_we_s    = 1'b1;
                        set_dirty_s = 1'b1;
                    end else begin
                        cpu_dout_nxt_s = arr_rdata_s;
                    end
                end else begin
                    // Point the read port at byte 0 so the first write-back byte is ready
                    arr_addr_s   = {req_idx_s, 5'd0};
                    k_nxt_s      = 5'd0;
                    mem_cs_nxt_s = 1'b1;
                    if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
                        state_nxt_s     = WRITEBACK;
                        mem_wr_rd_nxt_s = 1'b1;
                        mem_addr_nxt_s  = {tag_r[req_idx_s], req_idx_s, 5'd0};
                        mem_dout_nxt_s  = arr_rdata_s;
                    end else begin
                        state_nxt_s     = FILL;
                        mem_wr_rd_nxt_s = 1'b0;
                        mem_addr_nxt_s  = {req_tag_s, req_idx_s, 5'd0};
                    end
                end
            end
            WRITEBACK: begin
                arr_addr_s = {req_idx_s, k_inc_s};
                if (mem_ack) begin
                    if (k_r == LAST_OFF) begin
                        state_nxt_s     = FILL;
                        k_nxt_s         = 5'd0;
                        mem_wr_rd_nxt_s = 1'b0;
                        mem_addr_nxt_s  = {req_tag_s, req_idx_s, 5'd0};
                    end else begin
                        k_nxt_s        = k_inc_s;
                        mem_addr_nxt_s = {tag_r[req_idx_s], req_idx_s, k_inc_s};
                        mem_dout_nxt_s = arr_rdata_s;
                    end
                end else begin
                    k_nxt_s = k_r;
                end
            end
            FILL: begin
                arr_addr_s  = {req_idx_s, k_r};
                arr_wdata_s = mem_din;
                if (mem_ack) begin
                    arr_we_s = 1'b1;
                    if (k_r == LAST_OFF) begin
                        fill_done_s  = 1'b1;
                        state_nxt_s  = LOOKUP;
                        k_nxt_s      = 5'd0;
                        mem_cs_nxt_s = 1'b0;
                    end else begin
                        k_nxt_s        = k_inc_s;
                        mem_addr_nxt_s = {req_tag_s, req_idx_s, k_inc_s};
                    end
                end else begin
                    k_nxt_s = k_r;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                cpu_rdy_nxt_s = 1'b1;
                mem_cs_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter, request latch, line metadata and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= 5'd0;
            req_addr_r  <= 16'd0;
            req_wr_r    <= 1'b0;
            req_din_r   <= 8'd0;
            valid_r     <= 8'd0;
            dirty_r     <= 8'd0;
            cpu_rdy_r   <= 1'b1;
            cpu_dout_r  <= 8'd0;
            mem_cs_r    <= 1'b0;
            mem_wr_rd_r <= 1'b0;
            mem_addr_r  <= 16'd0;
            mem_dout_r  <= 8'd0;
            for (int i = 0; i < LINES; i++) begin
                tag_r[i] <= 8'd0;
            end
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            cpu_rdy_r   <= cpu_rdy_nxt_s;
            cpu_dout_r  <= cpu_dout_nxt_s;
            mem_cs_r    <= mem_cs_nxt_s;
            mem_wr_rd_r <= mem_wr_rd_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_dout_r  <= mem_dout_nxt_s;
            if (accept_s) begin
                req_addr_r <= cpu_addr;
                req_wr_r   <= cpu_wr_rd;
                req_din_r  <= cpu_din;
            end
            if (set_dirty_s) begin
                dirty_r[req_idx_s] <= 1'b1;
            end
            if (fill_done_s) begin
                tag_r[req_idx_s]   <= req_tag_s;
                valid_r[req_idx_s] <= 1'b1;
                dirty_r[req_idx_s] <= 1'b0;
            end
        end
    end

    assign cpu_rdy   = cpu_rdy_r;
    assign cpu_dout  = cpu_dout_r;
    assign mem_cs    = mem_cs_r;
    assign mem_wr_rd = mem_wr_rd_r;
    assign mem_addr  = mem_addr_r;
    assign mem_dout  = mem_dout_r;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: random-latency memory model, line-level cache reference model,
// directed plan steps followed by random requests.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_wr_rd;
    logic        cpu_cs;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic        mem_wr_rd;
    logic        mem_cs;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ack;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wr_rd (cpu_wr_rd),
        .cpu_cs    (cpu_cs),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_wr_rd (mem_wr_rd),
        .mem_cs    (mem_cs),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } xfer_t;

    xfer_t log_q[$];
    xfer_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    bit         m_valid [8];
    bit         m_dirty [8];
    logic [7:0] m_tag   [8];
    logic [7:0] m_data  [8][32];
    logic [7:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: cache behaviour at line granularity, also producing the expected memory traffic
    task automatic model_req(input logic [15:0] a, input logic wr, input logic [7:0] d, output bit hit);
        logic [2:0] idx;
        logic [4:0] off;
        logic [7:0] t;
        idx = a[7:5];
        off = a[4:0];
        t   = a[15:8];
        exp_q.delete();
        hit = m_valid[idx] && (m_tag[idx] == t);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int k = 0; k < 32; k++) begin
                    exp_q.push_back({1'b1, m_tag[idx], idx, 5'(k), m_data[idx][k]});
                end
            end
            for (int k = 0; k < 32; k++) begin
                exp_q.push_back({1'b0, t, idx, 5'(k), 8'h00});
                m_data[idx][k] = {idx, 5'(k)};
            end
            m_tag[idx]   = t;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_data[idx][off] = d;
            m_dirty[idx]     = 1'b1;
        end else begin
            m_dout = m_data[idx][off];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_dout = 8'h00;
    endtask

    // Memory: data = low address byte, ack after 0..3 cycles, occasional stray ack while idle
    initial begin : mem_model
        int          wait_cnt;
        logic        prev_cs, prev_ack, prev_wr;
        logic [15:0] prev_addr;
        logic [7:0]  prev_dout;
        wait_cnt = 0;
        prev_cs = 1'b0; prev_ack = 1'b0; prev_wr = 1'b0;
        prev_addr = 16'h0; prev_dout = 8'h0;
        mem_ack = 1'b0;
        mem_din = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_cs && prev_cs && !prev_ack && !rst) begin
                chk("mem_stable", 32'({mem_wr_rd, mem_addr, mem_dout}),
                    32'({prev_wr, prev_addr, prev_dout}));
            end
            prev_cs = mem_cs; prev_wr = mem_wr_rd; prev_addr = mem_addr; prev_dout = mem_dout;
            mem_ack = 1'b0;
            if (mem_cs) begin
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_din = mem_addr[7:0];
                    log_q.push_back({mem_wr_rd, mem_addr, mem_wr_rd ? mem_dout : 8'h00});
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
                mem_din = 8'hEE;
            end
            prev_ack = mem_ack;
        end
    end

    task automatic do_req(input logic [15:0] a, input logic wr, input logic [7:0] d, input bit hold);
        bit hit;
        int cycles;
        int nmin;
        chk("rdy_before_req", 32'(cpu_rdy), 32'd1);
        model_req(a, wr, d, hit);
        log_q.delete();
        cpu_addr = a; cpu_wr_rd = wr; cpu_din = d; cpu_cs = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycles = 0;
        if (!hold) cpu_cs = 1'b0;
        while (!cpu_rdy && cycles < 1000) begin
            if (hold) begin
                cpu_addr  = 16'($urandom);
                cpu_wr_rd = 1'($urandom_range(0, 1));
                cpu_din   = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        cpu_cs = 1'b0;
        cpu_wr_rd = 1'b0;
        chk("timeout", 32'(cycles < 1000), 32'd1);
        if (hit) begin
            chk("hit_latency", 32'(cycles), 32'd1);
        end else begin
            nmin = (exp_q.size() == 64) ? 66 : 34;
            chk("miss_latency_min", 32'(cycles >= nmin), 32'd1);
        end
        chk("xfer_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("xfer", 32'(log_q[i]), 32'(exp_q[i]));
        end
        chk("cpu_dout", 32'(cpu_dout), 32'(m_dout));
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_req", 32'({cpu_rdy, mem_cs}), 32'(2'b10));
        chk("no_extra_xfer", 32'(log_q.size()), 32'(exp_q.size()));
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] tags [4];
        int cnt;
        tags[0] = 8'h12; tags[1] = 8'h52; tags[2] = 8'h7F; tags[3] = 8'h00;
        rst = 1'b1; cpu_cs = 1'b0; cpu_addr = 16'h0; cpu_wr_rd = 1'b0; cpu_din = 8'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({cpu_rdy, cpu_dout, mem_cs, mem_wr_rd, mem_addr, mem_dout}),
            32'({1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00}));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        do_req(16'h1234, 1'b0, 8'h00, 1'b0);
        chk("cold_read_dout", 32'(cpu_dout), 32'h34);
        do_req(16'h1235, 1'b0, 8'h00, 1'b0);
        chk("hit_read_dout", 32'(cpu_dout), 32'h35);
        do_req(16'h1236, 1'b1, 8'hAA, 1'b0);
        do_req(16'h1236, 1'b0, 8'h00, 1'b0);
        chk("write_hit_readback", 32'(cpu_dout), 32'hAA);
        do_req(16'h5236, 1'b0, 8'h00, 1'b0);
        chk("conflict_dout", 32'(cpu_dout), 32'h36);
        chk("conflict_wb_byte16", 32'(exp_q.size() > 22 ? exp_q[22].data : 8'h00), 32'hAA);
        do_req(16'h9A40, 1'b0, 8'h00, 1'b1);
        chk("held_cs_dout", 32'(cpu_dout), 32'h40);

        // Abort a clean fill of line 4 after ten bytes
        log_q.delete();
        cpu_addr = 16'h7788; cpu_wr_rd = 1'b0; cpu_cs = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_cs = 1'b0;
        cnt = 0;
        while (log_q.size() < 10 && cnt < 500) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        chk("reach_fill_byte10", 32'(cnt < 500), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_outputs", 32'({mem_cs, cpu_rdy, cpu_dout}), 32'({1'b0, 1'b1, 8'h00}));
        do_req(16'h7788, 1'b0, 8'h00, 1'b0);
        chk("refill_dout", 32'(cpu_dout), 32'h88);
        do_req(16'h1236, 1'b0, 8'h00, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_req({tags[$urandom_range(0, 3)], 8'($urandom)}, 1'($urandom_range(0, 1)),
                   8'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
